// File: rtl/ifetch_bus_ctrl.sv
// Instruction-fetch bus controller: turns pc/ce fetch requests into single
// Wishbone classic reads, stalls the PC while a read is outstanding, holds the
// returned word while IF is stalled and discards words from flushed fetches.
//
// state | meaning
// IDLE  | no bus cycle; launch on ce & ~flush & ~stall[1]
// BUSY  | read outstanding, PC frozen via stallreq_o
// HOLD  | word received while IF stalled; presented from buffer
// DRAIN | fetch flushed; wait out the bus cycle and drop the data
module ifetch_bus_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [31:0] wb_adr_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] inst_o,
    output logic        stallreq_o,
    output logic        bus_err_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic          cyc_nx;
    logic [31:0]   adr_nx;
    logic [31:0]   buffer, buffer_nx;
    logic          err_nx;
    logic          stall_if;
    logic          launch;
    logic          timeout;
    logic          unused_stall;

    assign stall_if     = stall_i[1];
    assign unused_stall = ^{stall_i[5:2], stall_i[0]};
    assign launch       = ce_i & ~flush_i & ~stall_if;
    assign timeout      = (count == TC);

    assign wb_we_o  = 1'b0;
    assign wb_sel_o = 4'b1111;

    // State register and registered bus/error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_adr_o  <= '0;
            buffer    <= '0;
            bus_err_o <= 1'b0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            wb_cyc_o  <= cyc_nx;
            wb_stb_o  <= cyc_nx;
            wb_adr_o  <= adr_nx;
            buffer    <= buffer_nx;
            bus_err_o <= err_nx;
        end
    end

    // Next-state logic plus combinational inst_o/stallreq_o.
    // An ack always beats a coincident timeout; an ack with flush discards data.
    always_comb begin
        state_nx   = state;
        count_nx   = count;
        cyc_nx     = wb_cyc_o;
        adr_nx     = wb_adr_o;
        buffer_nx  = buffer;
        err_nx     = 1'b0;
        inst_o     = 32'h0;
        stallreq_o = 1'b0;
        case (state)
            IDLE: begin
                if (launch) begin
                    stallreq_o = 1'b1;
                    state_nx   = BUSY;
                    cyc_nx     = 1'b1;
                    adr_nx     = pc_i;
                    count_nx   = '0;
                end
            end
            BUSY: begin
                if (wb_ack_i) begin
                    cyc_nx = 1'b0;
                    if (flush_i) begin
                        state_nx = IDLE;
                    end else if (!stall_if) begin
                        inst_o   = wb_dat_i;
                        state_nx = IDLE;
                    end else begin
                        buffer_nx = wb_dat_i;
                        state_nx  = HOLD;
                    end
                end else if (timeout) begin
                    cyc_nx   = 1'b0;
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else if (flush_i) begin
                    count_nx = count + CW'(1);
                    state_nx = DRAIN;
                end else begin
                    stallreq_o = 1'b1;
                    count_nx   = count + CW'(1);
                end
            end
            DRAIN: begin
                if (wb_ack_i) begin
                    cyc_nx   = 1'b0;
                    state_nx = IDLE;
                end else if (timeout) begin
                    cyc_nx   = 1'b0;
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    count_nx = count + CW'(1);
                end
            end
            HOLD: begin
                if (flush_i) begin
                    state_nx = IDLE;
                end else begin
                    inst_o = buffer;
                    if (!stall_if) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (rst) begin
            inst_o     = 32'h0;
            stallreq_o = 1'b0;
        end
    end

endmodule
